estadistica_comparador: RTL and testbench
=========================================

# estadistica_comparador

Registered statistics and stability stage placed directly downstream of the 3-bit magnitude comparator. It consumes the comparator's result code each cycle a sample is flagged valid, and keeps saturating tallies of greater / equal / less outcomes. It also tracks runs of identical results and raises a stable flag once the same result has persisted for a programmable number of samples. It flags illegal result codes with a sticky error.

## Interface
Parameters:
- CNT_W, 8, width of each outcome tally (legal range 2..16)
- STABLE_N, 4, consecutive identical valid samples required to declare stability (legal range 2..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- valid_in  in  1  res is sampled this cycle when high
- res  in  3  comparator result code: 3'b100 a>b, 3'b000 a==b, 3'b001 a<b; any other value is illegal
- clear  in  1  synchronous clear of tallies, error, run tracking
- cnt_mayor  out  CNT_W  count of legal 3'b100 samples
- cnt_igual  out  CNT_W  count of legal 3'b000 samples
- cnt_menor  out  CNT_W  count of legal 3'b001 samples
- estable  out  1  high while FSM is in ESTABLE
- codigo_estable  out  3  result code latched on last entry to ESTABLE
- cambio  out  1  one-cycle pulse on each transition into ESTABLE
- err  out  1  sticky; set by any valid illegal code

## Operation
- All outputs registered. On rst_n low: all counters 0, codigo_estable 3'b000, estable 0, cambio 0, err 0, FSM VACIO, internal run count 0, internal last code 3'b000.
- Legal sample = valid_in high and res in {100, 000, 001}. Each legal sample increments exactly one tally; each tally saturates at 2^CNT_W-1 and does not wrap.
- Illegal sample = valid_in high with any other res: err set to 1 and held until clear or reset. Tallies, run count and FSM are unchanged.
- valid_in low: no state change except the cambio return-to-0.
- FSM, with internal run count (4 bits, saturating at STABLE_N) and last code:
  - VACIO: no legal sample since reset/clear. A legal sample sets last=res, run=1, next SEGUIR.
  - SEGUIR: legal sample with res==last sets run=run+1. If the new run equals STABLE_N, go to ESTABLE, set codigo_estable=res, and pulse cambio. Legal sample with res!=last sets last=res, run=1, and stays in SEGUIR.
  - ESTABLE: legal sample with res==last stays, with run held at STABLE_N. Legal sample with res!=last sets last=res, run=1, next SEGUIR. codigo_estable keeps its value.
- cambio is high for exactly the one cycle after each SEGUIR->ESTABLE transition, otherwise 0.
- clear (synchronous) has priority over a coincident sample; that sample is dropped. clear zeros the tallies, err, cambio, estable and run, sets codigo_estable to 3'b000, and sets FSM to VACIO.

## Timing
- Latency: every output reflects a sample on the clock edge that captures it. Outputs are visible 1 cycle after valid_in/res are presented.
- A sample can be accepted every cycle; no backpressure. The upstream comparator output is assumed stable at the capturing edge.
- Earliest ESTABLE: STABLE_N consecutive legal identical samples. estable rises on the edge that captures the STABLE_N-th sample.
- Non-consecutive valid cycles (gaps with valid_in low) do not break a run. Only a differing legal code does; illegal codes neither extend nor break a run.
- Assertion of rst_n low at any time, mid-run included, forces reset values immediately, without waiting for a clock edge. Deassertion is expected to be synchronized externally.

## Test plan
- Reset with rst_n=0 mid-run, asynchronous to clk -> all outputs go to 0 before the next edge; FSM returns to VACIO.
- STABLE_N=4: four valid res=100 back-to-back -> cnt_mayor 1,2,3,4; estable=1 and cambio=1 after the 4th sample; codigo_estable=100; cambio=0 the next cycle.
- Sequence 001,001,001,000,001 (STABLE_N=4) -> cnt_menor=4, cnt_igual=1, estable never asserts, run restarts at each change.
- In ESTABLE on 000, send res=011 -> err=1, tallies unchanged, estable stays 1. Then send 001 -> estable=0, codigo_estable stays 000.
- CNT_W=2: five res=000 samples -> cnt_igual ends at 3 (saturated, no wrap).
- clear together with valid res=100 -> all tallies 0, err 0, FSM VACIO, sample not counted; the next legal sample starts a run at 1.

Source files
------------

// File: rtl/estadistica_comparador.sv
// Statistics and stability stage behind the 3-bit magnitude comparator:
// saturating outcome tallies, run tracking with a stable flag, sticky illegal-code error.
module estadistica_comparador #(
    parameter int CNT_W    = 8,
    parameter int STABLE_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [2:0]       res,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt_mayor,
    output logic [CNT_W-1:0] cnt_igual,
    output logic [CNT_W-1:0] cnt_menor,
    output logic             estable,
    output logic [2:0]       codigo_estable,
    output logic             cambio,
    output logic             err
);

    typedef enum logic [1:0] {
        VACIO   = 2'd0,
        SEGUIR  = 2'd1,
        ESTABLE = 2'd2
    } estado_t;

    localparam logic [2:0]       COD_MAYOR = 3'b100;
    localparam logic [2:0]       COD_IGUAL = 3'b000;
    localparam logic [2:0]       COD_MENOR = 3'b001;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_UNO   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       RUN_OBJ   = 4'(STABLE_N);

    estado_t    estado;
    logic [3:0] run;
    logic [2:0] ultimo;
    logic       codigo_ok;
    logic       legal;
    logic       ilegal;
    logic       repite;

    assign codigo_ok = (res == COD_MAYOR) || (res == COD_IGUAL) || (res == COD_MENOR);
    assign legal     = valid_in && codigo_ok;
    assign ilegal    = valid_in && !codigo_ok;
    assign repite    = (res == ultimo);

    // Tallies stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_mayor <= '0;
            cnt_igual <= '0;
            cnt_menor <= '0;
        end else if (clear) begin
            cnt_mayor <= '0;
            cnt_igual <= '0;
            cnt_menor <= '0;
        end else if (legal) begin
            case (res)
                COD_MAYOR: if (cnt_mayor != CNT_MAX) cnt_mayor <= cnt_mayor + CNT_UNO;
                COD_IGUAL: if (cnt_igual != CNT_MAX) cnt_igual <= cnt_igual + CNT_UNO;
                COD_MENOR: if (cnt_menor != CNT_MAX) cnt_menor <= cnt_menor + CNT_UNO;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (ilegal) begin
            err <= 1'b1;
        end
    end

    // Illegal codes fall outside `legal`, so they neither extend nor break a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= VACIO;
            run            <= 4'd0;
            ultimo         <= 3'b000;
            estable        <= 1'b0;
            codigo_estable <= 3'b000;
            cambio         <= 1'b0;
        end else begin
            cambio <= 1'b0;
            if (clear) begin
                estado         <= VACIO;
                run            <= 4'd0;
                ultimo         <= 3'b000;
                estable        <= 1'b0;
                codigo_estable <= 3'b000;
            end else if (legal) begin
                case (estado)
                    VACIO: begin
                        ultimo <= res;
                        run    <= 4'd1;
                        estado <= SEGUIR;
                    end
                    SEGUIR: begin
                        if (repite) begin
                            if ((run + 4'd1) == RUN_OBJ) begin
                                run            <= RUN_OBJ;
                                estado         <= ESTABLE;
                                estable        <= 1'b1;
                                codigo_estable <= res;
                                cambio         <= 1'b1;
                            end else begin
                                run <= run + 4'd1;
                            end
                        end else begin
                            ultimo <= res;
                            run    <= 4'd1;
                        end
                    end
                    ESTABLE: begin
                        if (repite) begin
                            run <= RUN_OBJ;
                        end else begin
                            ultimo  <= res;
                            run     <= 4'd1;
                            estado  <= SEGUIR;
                            estable <= 1'b0;
                        end
                    end
                    default: begin
                        estado  <= VACIO;
                        run     <= 4'd0;
                        estable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_estadistica_comparador.sv
// Scoreboard bench: two instances (CNT_W=8 and CNT_W=2) share stimulus; directed
// vectors push hand-computed expectations, a negedge monitor pops and compares.
module tb_estadistica_comparador;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [2:0] res;
    logic       clear;

    logic [7:0] cnt_mayor8, cnt_igual8, cnt_menor8;
    logic [1:0] cnt_mayor2, cnt_igual2, cnt_menor2;
    logic       estable8, cambio8, err8;
    logic       estable2, cambio2, err2;
    logic [2:0] codigo8, codigo2;

    typedef struct {
        int m;
        int i;
        int l;
        int est;
        int cod;
        int cam;
        int er;
    } esperado_t;

    esperado_t esperados[$];
    int checks = 0;
    int errors = 0;

    estadistica_comparador #(.CNT_W(8), .STABLE_N(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .res(res), .clear(clear),
        .cnt_mayor(cnt_mayor8), .cnt_igual(cnt_igual8), .cnt_menor(cnt_menor8),
        .estable(estable8), .codigo_estable(codigo8), .cambio(cambio8), .err(err8)
    );

    estadistica_comparador #(.CNT_W(2), .STABLE_N(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .res(res), .clear(clear),
        .cnt_mayor(cnt_mayor2), .cnt_igual(cnt_igual2), .cnt_menor(cnt_menor2),
        .estable(estable2), .codigo_estable(codigo2), .cambio(cambio2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat2(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic checkField(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input esperado_t e);
        checkField("cnt_mayor8", int'(cnt_mayor8), e.m);
        checkField("cnt_igual8", int'(cnt_igual8), e.i);
        checkField("cnt_menor8", int'(cnt_menor8), e.l);
        checkField("cnt_mayor2", int'(cnt_mayor2), sat2(e.m));
        checkField("cnt_igual2", int'(cnt_igual2), sat2(e.i));
        checkField("cnt_menor2", int'(cnt_menor2), sat2(e.l));
        checkField("estable8", int'(estable8), e.est);
        checkField("estable2", int'(estable2), e.est);
        checkField("codigo8", int'(codigo8), e.cod);
        checkField("codigo2", int'(codigo2), e.cod);
        checkField("cambio8", int'(cambio8), e.cam);
        checkField("cambio2", int'(cambio2), e.cam);
        checkField("err8", int'(err8), e.er);
        checkField("err2", int'(err2), e.er);
    endtask

    // Drive one cycle of input, then queue the state expected after the capturing edge.
    task automatic applyStimulus(input logic clr, input logic v, input logic [2:0] r,
                                 input int m, input int i, input int l, input int est,
                                 input int cod, input int cam, input int er);
        esperado_t e;
        @(negedge clk);
        clear    = clr;
        valid_in = v;
        res      = r;
        @(posedge clk);
        e = '{m: m, i: i, l: l, est: est, cod: cod, cam: cam, er: er};
        esperados.push_back(e);
    endtask

    task automatic waitDrained();
        int budget = 20;
        while (esperados.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (esperados.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d expected=0 pending entries", esperados.size());
            esperados.delete();
        end
    endtask

    initial begin : monitor
        esperado_t e;
        forever begin
            @(negedge clk);
            if (esperados.size() > 0) begin
                e = esperados.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        esperado_t cero;
        cero = '{m: 0, i: 0, l: 0, est: 0, cod: 0, cam: 0, er: 0};
        rst_n    = 1'b0;
        valid_in = 1'b0;
        res      = 3'b000;
        clear    = 1'b0;
        #12;
        checkOutput(cero);
        @(negedge clk);
        rst_n = 1'b1;

        //             clr  v   res     m  i  l  est cod cam er
        applyStimulus(0, 1, 3'b100, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 4, 0, 0, 1, 4, 1, 0);
        applyStimulus(0, 0, 3'b000, 4, 0, 0, 1, 4, 0, 0);
        applyStimulus(0, 1, 3'b001, 4, 0, 1, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b001, 4, 0, 2, 0, 4, 0, 0);
        applyStimulus(0, 0, 3'b001, 4, 0, 2, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b001, 4, 0, 3, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b000, 4, 1, 3, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b001, 4, 1, 4, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b000, 4, 2, 4, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b000, 4, 3, 4, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b000, 4, 4, 4, 0, 4, 0, 0);
        applyStimulus(0, 1, 3'b000, 4, 5, 4, 1, 0, 1, 0);
        applyStimulus(0, 1, 3'b011, 4, 5, 4, 1, 0, 0, 1);
        applyStimulus(0, 1, 3'b001, 4, 5, 5, 0, 0, 0, 1);
        applyStimulus(0, 1, 3'b110, 4, 5, 5, 0, 0, 0, 1);
        applyStimulus(1, 1, 3'b100, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 4, 0, 0, 1, 4, 1, 0);
        applyStimulus(0, 1, 3'b100, 5, 0, 0, 1, 4, 0, 0);
        applyStimulus(0, 1, 3'b011, 5, 0, 0, 1, 4, 0, 1);
        applyStimulus(0, 1, 3'b001, 5, 0, 1, 0, 4, 0, 1);
        waitDrained();

        // Asynchronous reset between edges while samples keep arriving.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput(cero);
        @(negedge clk);
        rst_n = 1'b1;
        valid_in = 1'b0;

        applyStimulus(0, 1, 3'b100, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 4, 0, 0, 1, 4, 1, 0);
        @(negedge clk);
        valid_in = 1'b0;
        waitDrained();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
